uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-003 SHALL have port reset_x  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port RXD  input  1  UART serial in, 8N1, idle high.
REQ-005 SHALL have port ADDR  output  `ADDR_LEN  byte address of the word being written.
REQ-006 SHALL have port DATA  output  4*`INSN_LEN  image shift register; latest 32-bit word in [127:96].
REQ-007 SHALL have port WE_32  output  1  one-cycle dmem write strobe.
REQ-008 SHALL have port WE_128  output  1  one-cycle imem write strobe.
REQ-009 SHALL have port DONE  output  1  sticky: image fully written.
REQ-010 SHALL have port ERR  output  1  sticky: framing error (or checksum mismatch, see Configuration).

Function
REQ-011 RXD SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-012 Receiver: falling edge starts bit timer; start bit re-sampled at CLKS_PER_BIT/2; if high, SHALL return to idle with no byte.
REQ-013 Data bits SHALL be sampled at bit centres, LSB first; stop bit sampled at centre.
REQ-014 Stop bit 0 SHALL discard the byte, set ERR, and return receiver to idle.
REQ-015 Valid byte SHALL produce a one-cycle rx_valid pulse to the loader FSM.
REQ-016 Loader FSM states: HDR, DATA, PAD, [CSUM], FIN; reset state HDR.
REQ-017 HDR: first 4 bytes form length L, little-endian (byte0 = L[7:0]); after 4th byte go to DATA, or if L==0 to CSUM/FIN.
REQ-018 DATA: each byte SHALL shift in as DATA <= {byte, DATA[127:8]}; byte counter increments.
REQ-019 After every 4th image byte, WE_32 SHALL pulse the next cycle with ADDR = byte address of that word's first byte (0, 4, 8, ...).
REQ-020 After every 16th image byte, WE_128 SHALL pulse in the same cycle as that word's WE_32, with the same ADDR.
REQ-021 When L bytes received and L mod 16 != 0, PAD SHALL shift in 0x00 one byte per cycle, issuing strobes per REQ-019/020, until the 16-byte boundary.
REQ-022 After the last strobe, go to CSUM (if compiled) else FIN; FIN SHALL set DONE and hold until reset.
REQ-023 In FIN, received bytes SHALL be ignored; outputs SHALL stay frozen.
REQ-024 rx_valid arriving during PAD cannot occur before PAD ends (PAD ≤ 15 cycles < 1 byte time); any such byte SHALL be dropped.
REQ-025 Length counter SHALL be 32 bits; no capacity check.

Reset
REQ-026 Assertion of reset_x low SHALL asynchronously clear ADDR, DATA, WE_32, WE_128, DONE, ERR, counters to 0, FSM to HDR, receiver to idle.
REQ-027 Reset mid-byte or mid-image SHALL abandon the transfer; next byte after release is header byte0.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: after image, CSUM state SHALL receive one byte; if it differs from sum mod 256 of the L image bytes (pad excluded), ERR SHALL set; DONE sets either way.
REQ-029 Macro undefined: no CSUM state, no accumulator; ERR reflects framing errors only.

Structure
REQ-030 `ADDR_LEN, `INSN_LEN, `DATA_LEN SHALL come from define.v; loader state encodings and LDR_HDR_BYTES (4) SHALL live in constants.vh.
REQ-031 Receiver SHALL be sub-module uart_rx_8n1 (ports clk, reset_x, rxd, data[7:0], valid, ferr); loader FSM in uart_prog_loader.

Verification (CLKS_PER_BIT=8 for benches)
REQ-032 Send L=4, bytes 0x13,0x00,0x00,0x00 -> WE_32 once, ADDR=0, DATA[127:96]=0x00000013; 12 pad cycles; WE_32+WE_128 at ADDR=12; DONE=1.
REQ-033 Send L=32, bytes 0x00..0x1F -> 8 WE_32 (ADDR 0..28), WE_128 at ADDR 12 with DATA=0x0F0E..00, at ADDR 28 with DATA=0x1F1E..10; no pad.
REQ-034 Glitch RXD low for 2 cycles -> no byte, no strobe, ERR=0.
REQ-035 Byte with stop bit 0 -> ERR=1, byte not counted; following good bytes still load.
REQ-036 reset_x low after 6 image bytes -> all outputs 0 immediately; resend L=16 image -> correct 4 WE_32, 1 WE_128, DONE.
REQ-037 LOADER_CHECKSUM_EN: L=4 image 01 02 03 04 with checksum 0x0A -> DONE=1, ERR=0; checksum 0x0B -> DONE=1, ERR=1.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_prog_loader_pkg: shared widths and state encodings. Revision: 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_prog_loader_pkg;

  localparam int ADDR_LEN      = 32;
  localparam int INSN_LEN      = 32;
  localparam int LDR_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    LDR_HDR  = 3'd0,
    LDR_DATA = 3'd1,
    LDR_PAD  = 3'd2,
    LDR_CSUM = 3'd3,
    LDR_FIN  = 3'd4
  } ldr_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_prog_loader_if.sv
// +--------------------------------------------------------------------------+
// | uart_prog_loader_if: serial input and memory-write bus. Revision: 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

interface uart_prog_loader_if;
  import uart_prog_loader_pkg::*;

  logic                  RXD;
  logic [ADDR_LEN-1:0]   ADDR;
  logic [4*INSN_LEN-1:0] DATA;
  logic                  WE_32;
  logic                  WE_128;
  logic                  DONE;
  logic                  ERR;

  modport master (input RXD, output ADDR, DATA, WE_32, WE_128, DONE, ERR);
  modport slave  (output RXD, input ADDR, DATA, WE_32, WE_128, DONE, ERR);

endinterface

`default_nettype wire

// File: rtl/uart_rx_8n1.sv
// +--------------------------------------------------------------------------+
// | uart_rx_8n1: 8N1 receiver with 2-flop input sync. Revision: 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_8n1
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_x,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);

  localparam int            CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      // A true falling edge is required, so a line still low after a bad stop bit is not a start.
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BITS: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data  = shift_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/uart_prog_loader.sv
// +--------------------------------------------------------------------------+
// | uart_prog_loader: UART image loader; LOADER_CHECKSUM_EN adds a checksum. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clk,
  input  logic               reset_x,
  uart_prog_loader_if.master bus
);

`ifdef LOADER_CHECKSUM_EN
  localparam ldr_state_e AFTER_IMG = LDR_CSUM;
`else
  localparam ldr_state_e AFTER_IMG = LDR_FIN;
`endif

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .reset_x (reset_x),
    .rxd     (bus.RXD),
    .data    (rx_data),
    .valid   (rx_valid),
    .ferr    (rx_ferr)
  );

  ldr_state_e            state_q, state_d;
  logic [31:0]           len_q, len_d;
  logic [1:0]            hdr_cnt_q, hdr_cnt_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic [4*INSN_LEN-1:0] data_q, data_d;
  logic                  we32_q, we32_d;
  logic                  we128_q, we128_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           cnt_inc;
  logic [31:0]           len_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  assign cnt_inc  = cnt_q + 32'd1;
  assign len_next = {rx_data, len_q[31:8]};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hdr_cnt_d = hdr_cnt_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we32_d    = 1'b0;
    we128_d   = 1'b0;
    done_d    = done_q;
    err_d     = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    if (rx_ferr && state_q != LDR_FIN) err_d = 1'b1;
    // Word strobes fire on the byte that completes each 4-byte (and 16-byte) group.
    if ((state_q == LDR_DATA && rx_valid) || state_q == LDR_PAD) begin
      data_d = {(state_q == LDR_DATA) ? rx_data : 8'h00, data_q[4*INSN_LEN-1:8]};
      cnt_d  = cnt_inc;
      if (cnt_inc[1:0] == 2'b00) begin
        we32_d  = 1'b1;
        we128_d = (cnt_inc[3:0] == 4'd0);
        addr_d  = ADDR_LEN'({cnt_q[31:2], 2'b00});
      end
    end
    case (state_q)
      LDR_HDR: begin
        if (rx_valid) begin
          len_d     = len_next;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(LDR_HDR_BYTES - 1))
            state_d = (len_next == 32'd0) ? AFTER_IMG : LDR_DATA;
        end
      end
      LDR_DATA: begin
        if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          if (cnt_inc == len_q)
            state_d = (cnt_inc[3:0] == 4'd0) ? AFTER_IMG : LDR_PAD;
        end
      end
      LDR_PAD: begin
        if (cnt_inc[3:0] == 4'd0) state_d = AFTER_IMG;
      end
`ifdef LOADER_CHECKSUM_EN
      LDR_CSUM: begin
        if (rx_valid) begin
          if (rx_data != sum_q) err_d = 1'b1;
          state_d = LDR_FIN;
        end
      end
`endif
      LDR_FIN: done_d = 1'b1;
      default: state_d = LDR_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q   <= LDR_HDR;
      len_q     <= '0;
      hdr_cnt_q <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we32_q    <= 1'b0;
      we128_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hdr_cnt_q <= hdr_cnt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we32_q    <= we32_d;
      we128_q   <= we128_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign bus.ADDR   = addr_q;
  assign bus.DATA   = data_q;
  assign bus.WE_32  = we32_q;
  assign bus.WE_128 = we128_q;
  assign bus.DONE   = done_q;
  assign bus.ERR    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
// +--------------------------------------------------------------------------+
// | tb_uart_prog_loader: directed + random image loads vs a byte-level model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_prog_loader;
  import uart_prog_loader_pkg::*;

  localparam int CPB = 8;

  logic clk     = 1'b0;
  logic reset_x = 1'b0;

  uart_prog_loader_if bus ();

  uart_prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_x (reset_x),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we32;
    logic         we128;
    logic [31:0]  addr;
    logic [127:0] data;
    int           cyc;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] cur_img[$];
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.WE_32 || bus.WE_128)
      evq.push_back('{bus.WE_32, bus.WE_128, bus.ADDR, bus.DATA, cyc});

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ADDR"},   128'(bus.ADDR),   128'd0);
    check({tag, " DATA"},   bus.DATA,         128'd0);
    check({tag, " WE_32"},  128'(bus.WE_32),  128'd0);
    check({tag, " WE_128"}, 128'(bus.WE_128), 128'd0);
    check({tag, " DONE"},   128'(bus.DONE),   128'd0);
    check({tag, " ERR"},    128'(bus.ERR),    128'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_x = 1'b0;
    #1;
    check_zero(tag);
    repeat (3) @(negedge clk);
    evq.delete();
    reset_x = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(negedge clk);
    bus.RXD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RXD = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.RXD = stop;
    repeat (CPB) @(negedge clk);
    bus.RXD = 1'b1;
    if (!stop) repeat (2 * CPB) @(negedge clk);
  endtask

  // Header + image (+ checksum), with an optional framing-error byte injected
  // before stream byte ferr_at; a trailing byte is sent after DONE to test freezing.
  task automatic send_image(input bit bad_csum, input int ferr_at);
    logic [7:0]  stream[$];
    logic [31:0] len;
    logic [7:0]  sum;
    len = 32'(cur_img.size());
    sum = 8'd0;
    for (int i = 0; i < 4; i++) stream.push_back(len[8*i +: 8]);
    foreach (cur_img[i]) begin
      stream.push_back(cur_img[i]);
      sum = sum + cur_img[i];
    end
    sum = sum + {7'd0, bad_csum};
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(sum);
`endif
    foreach (stream[i]) begin
      if (i == ferr_at) send_byte(8'h5A, 1'b0);
      send_byte(stream[i], 1'b1);
    end
    for (int i = 0; i < 400 && !bus.DONE; i++) @(negedge clk);
    send_byte(sum ^ 8'hC3, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic compare(input string tag, input bit exp_err);
    logic [7:0]   pad[$];
    logic [127:0] blk;
    logic [31:0]  top;
    int           nw;
    int           k;
    pad = cur_img;
    while (pad.size() % 16 != 0) pad.push_back(8'h00);
    nw = pad.size() / 4;
    check({tag, " strobes"}, 128'(evq.size()), 128'(nw));
    blk = '0;
    for (k = 0; k < nw && k < evq.size(); k++) begin
      top = {pad[4*k+3], pad[4*k+2], pad[4*k+1], pad[4*k]};
      for (int i = 0; i < 16; i++) blk[8*i +: 8] = pad[16*(k/4) + i];
      check($sformatf("%s ev%0d WE_32", tag, k),  128'(evq[k].we32), 128'd1);
      check($sformatf("%s ev%0d WE_128", tag, k), 128'(evq[k].we128), 128'(k % 4 == 3));
      check($sformatf("%s ev%0d ADDR", tag, k),   128'(evq[k].addr), 128'(4 * k));
      check($sformatf("%s ev%0d word", tag, k),   128'(evq[k].data[127:96]), 128'(top));
      if (k % 4 == 3)
        check($sformatf("%s ev%0d block", tag, k), evq[k].data, blk);
    end
    check({tag, " DONE"},  128'(bus.DONE), 128'd1);
    check({tag, " ERR"},   128'(bus.ERR),  128'(exp_err));
    check({tag, " final ADDR"}, 128'(bus.ADDR), (nw > 0) ? 128'(4 * (nw - 1)) : 128'd0);
    check({tag, " final DATA"}, bus.DATA, (nw > 0) ? blk : 128'd0);
  endtask

  task automatic rand_img(input int n);
    cur_img.delete();
    for (int i = 0; i < n; i++) cur_img.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    bus.RXD = 1'b1;
    #1;
    check_zero("por");
    repeat (3) @(negedge clk);
    reset_x = 1'b1;
    repeat (2) @(negedge clk);

    // Single word with 12 pad cycles
    cur_img = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_image(1'b0, -1);
    compare("L4", 1'b0);
    if (evq.size() == 4) check("L4 pad cycles", 128'(evq[3].cyc - evq[0].cyc), 128'd12);

    // Two full blocks, no pad
    do_reset("rst1");
    cur_img.delete();
    for (int i = 0; i < 32; i++) cur_img.push_back(8'(i));
    send_image(1'b0, -1);
    compare("L32", 1'b0);

    // Short glitch is not a byte; following load must see header byte0 intact
    do_reset("rst2");
    @(negedge clk);
    bus.RXD = 1'b0;
    repeat (2) @(negedge clk);
    bus.RXD = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch strobes", 128'(evq.size()), 128'd0);
    check("glitch ERR",     128'(bus.ERR),    128'd0);
    check("glitch DONE",    128'(bus.DONE),   128'd0);
    rand_img(4);
    send_image(1'b0, -1);
    compare("post-glitch", 1'b0);

    // Framing error inside header and inside image
    do_reset("rst3");
    rand_img(8);
    send_image(1'b0, 1);
    compare("ferr hdr", 1'b1);
    do_reset("rst4");
    rand_img(20);
    send_image(1'b0, 9);
    compare("ferr img", 1'b1);

    // Reset mid-image, then a clean L=16 load
    do_reset("rst5");
    send_byte(8'h10, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b1);
    #3;
    reset_x = 1'b0;
    #1;
    check_zero("mid-image reset");
    repeat (3) @(negedge clk);
    evq.delete();
    reset_x = 1'b1;
    repeat (2) @(negedge clk);
    rand_img(16);
    send_image(1'b0, -1);
    compare("L16 after reset", 1'b0);

    // Empty image
    do_reset("rst6");
    cur_img.delete();
    send_image(1'b0, -1);
    compare("L0", 1'b0);

    // Random lengths
    for (int t = 0; t < 4; t++) begin
      do_reset($sformatf("rst rnd%0d", t));
      rand_img($urandom_range(1, 40));
      send_image(1'b0, -1);
      compare($sformatf("rnd%0d L%0d", t, cur_img.size()), 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset("rst csum");
    cur_img = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_image(1'b0, -1);
    compare("csum good", 1'b0);
    do_reset("rst csum bad");
    send_image(1'b1, -1);
    compare("csum bad", 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
